// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer and the PC mux it steers.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RST_VEC  = 2'd0,
        RUN      = 2'd1,
        INT_PUSH = 2'd2,
        INT_VEC  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_INT    = 2'b00;
    localparam logic [1:0] SEL_FIRST  = 2'b01;
    localparam logic [1:0] SEL_NEXT   = 2'b10;
    localparam logic [1:0] SEL_BRANCH = 2'b11;

endpackage

// File: rtl/pc_sequencer.sv
// PC sequencing FSM: reset-vector fetch, normal run, interrupt PC save and
// interrupt-vector fetch. Exposes state and int_active for observation.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PUSH_BEATS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic       rti,
    input  logic       branch_taken,
    input  logic       stall,
    input  logic       mem_ready,
    output logic [1:0] pc_sel,
    output logic       pc_en,
    output logic       vec_rd,
    output logic       vec_sel,
    output logic       push_pc,
    output logic       flush,
    output logic       int_ack,
    output state_t     dbg_state,
    output logic       dbg_int_active
);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       int_active_q, int_active_d;
    logic       rel_q;
    logic       int_set;

    // Vector handshake: vec_rd is held as a request; the word is taken in
    // the cycle where mem_ready is seen with vec_rd high, and only then.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_set = 1'b0;
        pc_sel  = SEL_NEXT;
        pc_en   = 1'b0;
        vec_rd  = 1'b0;
        vec_sel = 1'b0;
        push_pc = 1'b0;
        flush   = 1'b0;
        int_ack = 1'b0;

        case (state_q)
            RST_VEC: begin
                // rel_q keeps the vector read off until the first clock after reset release.
                if (rel_q) begin
                    vec_rd = 1'b1;
                    if (mem_ready) begin
                        pc_sel  = SEL_FIRST;
                        pc_en   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (branch_taken) begin
                    pc_sel = SEL_BRANCH;
                    pc_en  = 1'b1;
                    flush  = 1'b1;
                end else if (stall) begin
                    pc_en = 1'b0;
                end else if (int_req && !int_active_q) begin
                    flush   = 1'b1;
                    int_set = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = INT_PUSH;
                end else begin
                    pc_sel = SEL_NEXT;
                    pc_en  = 1'b1;
                end
            end
            INT_PUSH: begin
                push_pc = 1'b1;
                if (cnt_q == 4'(PUSH_BEATS - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = INT_VEC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            INT_VEC: begin
                vec_rd  = 1'b1;
                vec_sel = 1'b1;
                if (mem_ready) begin
                    pc_sel  = SEL_INT;
                    pc_en   = 1'b1;
                    int_ack = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RST_VEC;
        endcase

        // Entry wins over a simultaneous rti.
        if (int_set) begin
            int_active_d = 1'b1;
        end else if (rti) begin
            int_active_d = 1'b0;
        end else begin
            int_active_d = int_active_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RST_VEC;
            cnt_q        <= 4'd0;
            int_active_q <= 1'b0;
            rel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            int_active_q <= int_active_d;
            rel_q        <= 1'b1;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_int_active = int_active_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with a queued expected-output scoreboard.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       int_req;
    logic       rti;
    logic       branch_taken;
    logic       stall;
    logic       mem_ready;
    logic [1:0] pc_sel;
    logic       pc_en;
    logic       vec_rd;
    logic       vec_sel;
    logic       push_pc;
    logic       flush;
    logic       int_ack;
    state_t     dbg_state;
    logic       dbg_int_active;

    pc_sequencer #(.PUSH_BEATS(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .int_req        (int_req),
        .rti            (rti),
        .branch_taken   (branch_taken),
        .stall          (stall),
        .mem_ready      (mem_ready),
        .pc_sel         (pc_sel),
        .pc_en          (pc_en),
        .vec_rd         (vec_rd),
        .vec_sel        (vec_sel),
        .push_pc        (push_pc),
        .flush          (flush),
        .int_ack        (int_ack),
        .dbg_state      (dbg_state),
        .dbg_int_active (dbg_int_active)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected vector: {pc_sel, pc_en, vec_rd, vec_sel, push_pc, flush, int_ack, int_active}
    logic [8:0] exp_q[$];
    string      name_q[$];
    int         n_applied = 0;
    int         n_miscmp  = 0;

    function automatic logic [8:0] ev(input logic [1:0] sel, input logic en, input logic vr,
                                      input logic vs, input logic pp, input logic fl,
                                      input logic ack, input logic ia);
        return {sel, en, vr, vs, pp, fl, ack, ia};
    endfunction

    // driver: one cycle of inputs plus the hand-computed outputs for that cycle
    task automatic cyc(input string nm, input logic r, input logic ir, input logic rt,
                       input logic br, input logic st, input logic mr, input logic [8:0] e);
        @(negedge clk);
        rst          = r;
        int_req      = ir;
        rti          = rt;
        branch_taken = br;
        stall        = st;
        mem_ready    = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // monitor: outputs are combinational and present every cycle
    initial begin
        logic [8:0] got;
        logic [8:0] want;
        string      nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = {pc_sel, pc_en, vec_rd, vec_sel, push_pc, flush, int_ack, dbg_int_active};
                n_applied++;
                if (got !== want) begin
                    n_miscmp++;
                    $display("FAIL %s: got %b want %b (sel,en,vrd,vsel,push,flush,ack,ia)",
                             nm, got, want);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; int_req = 1'b0; rti = 1'b0;
        branch_taken = 1'b0; stall = 1'b0; mem_ready = 1'b0;

        //   name          rst ir rti br st mr  expected
        cyc("rst_a",      1, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("rst_b",      1, 1, 0, 1, 0, 1, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("release",    0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("rv_c1",      0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,1,0,0,0,0,0));
        cyc("rv_c2",      0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,1,0,0,0,0,0));
        cyc("rv_c3_load", 0, 0, 0, 0, 0, 1, ev(SEL_FIRST,1,1,0,0,0,0,0));
        cyc("run1",       0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,0));
        cyc("run_mr_ign", 0, 0, 0, 0, 0, 1, ev(SEL_NEXT, 1,0,0,0,0,0,0));
        cyc("stall",      0, 0, 0, 0, 1, 0, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("stall_int",  0, 1, 0, 0, 1, 0, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("br_int_stl", 0, 1, 0, 1, 1, 0, ev(SEL_BRANCH,1,0,0,0,1,0,0));
        cyc("int_entry",  0, 1, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,0,1,0,0));
        cyc("push1_stl",  0, 0, 0, 0, 1, 0, ev(SEL_NEXT, 0,0,0,1,0,0,1));
        cyc("push2",      0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,1,0,0,1));
        cyc("ivec_wait",  0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,1,1,0,0,0,1));
        cyc("ivec_load",  0, 0, 0, 0, 0, 1, ev(SEL_INT,  1,1,1,0,0,1,1));
        cyc("masked1",    0, 1, 0, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,1));
        cyc("masked2",    0, 1, 0, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,1));
        cyc("rti_pulse",  0, 1, 1, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,1));
        cyc("int2_entry", 0, 1, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,0,1,0,0));
        cyc("int2_push1", 0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,1,0,0,1));
        cyc("rst_push2",  1, 0, 0, 0, 0, 1, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("rst_hold",   1, 1, 0, 0, 0, 1, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("release2",   0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,0,0,0,0));
        cyc("rv2_c1",     0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,1,0,0,0,0,0));
        cyc("rv2_load",   0, 0, 0, 0, 0, 1, ev(SEL_FIRST,1,1,0,0,0,0,0));
        cyc("run2",       0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,0));
        cyc("branch",     0, 0, 0, 1, 0, 0, ev(SEL_BRANCH,1,0,0,0,1,0,0));
        cyc("entry_rti",  0, 1, 1, 0, 0, 0, ev(SEL_NEXT, 0,0,0,0,1,0,0));
        cyc("p1_lost",    0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,1,0,0,1));
        cyc("p2_lost",    0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 0,0,0,1,0,0,1));
        cyc("ivec_fast",  0, 0, 0, 0, 0, 1, ev(SEL_INT,  1,1,1,0,0,1,1));
        cyc("still_mask", 0, 1, 0, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,1));
        cyc("rti2",       0, 0, 1, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,1));
        cyc("cleared",    0, 0, 0, 0, 0, 0, ev(SEL_NEXT, 1,0,0,0,0,0,0));

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_miscmp++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PUSH_BEATS, default 2: number of stack beats needed to save a 32-bit PC (range 1-15).
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port int_req, input, 1: level interrupt request.
REQ-005 SHALL have port rti, input, 1: one-cycle pulse at return-from-interrupt retirement.
REQ-006 SHALL have port branch_taken, input, 1: resolved taken branch/call/return this cycle.
REQ-007 SHALL have port stall, input, 1: hazard unit freezes fetch.
REQ-008 SHALL have port mem_ready, input, 1: vector word valid on the memory bus.
REQ-009 SHALL have port pc_sel, output, 2: PC mux select (00 interrupt, 01 first-instruction, 10 next, 11 branch).
REQ-010 SHALL have port pc_en, output, 1: PC mux/register load enable.
REQ-011 SHALL have port vec_rd, output, 1: vector read request.
REQ-012 SHALL have port vec_sel, output, 1: 0 = reset vector (M[0]), 1 = interrupt vector (M[1]).
REQ-013 SHALL have port push_pc, output, 1: save a PC beat to the stack this cycle.
REQ-014 SHALL have port flush, output, 1: squash fetch/decode this cycle.
REQ-015 SHALL have port int_ack, output, 1: one-cycle pulse on interrupt vector load.

Function
REQ-016 SHALL implement FSM states RST_VEC, RUN, INT_PUSH, INT_VEC.
REQ-017 RST_VEC: vec_rd=1, vec_sel=0, pc_en=0; on mem_ready: pc_sel=01, pc_en=1 in that cycle, next state RUN.
REQ-018 RUN priority, evaluated per cycle: branch_taken > stall > (int_req & !int_active) > sequential.
REQ-019 RUN, branch_taken: pc_sel=11, pc_en=1, flush=1, even while stall=1.
REQ-020 RUN, stall without branch: pc_en=0, pc_sel=10; pending interrupt deferred.
REQ-021 RUN, interrupt accepted: pc_en=0, flush=1, set int_active, beat counter=0, next INT_PUSH.
REQ-022 RUN, otherwise: pc_sel=10, pc_en=1.
REQ-023 Branch and interrupt in the same cycle: branch taken; interrupt taken on a later cycle if int_req is still high.
REQ-024 INT_PUSH: push_pc=1, pc_en=0 for exactly PUSH_BEATS consecutive cycles (counter 0..PUSH_BEATS-1), then INT_VEC; stall ignored.
REQ-025 INT_VEC: vec_rd=1, vec_sel=1, pc_en=0 until mem_ready; on mem_ready: pc_sel=00, pc_en=1, int_ack=1, next RUN.
REQ-026 int_active SHALL mask further interrupts until rti; rti clears it in any state; rti in the entry cycle is lost, because set wins.
REQ-027 mem_ready SHALL be ignored outside RST_VEC/INT_VEC.
REQ-028 Whenever pc_en=0, pc_sel SHALL be 10; flush, push_pc, int_ack, vec_rd SHALL be 0 unless set by REQ-017 to REQ-025.
REQ-029 Wait on mem_ready SHALL be unbounded; no timeout.

Reset
REQ-030 rst SHALL asynchronously force state RST_VEC, int_active=0, counter=0.
REQ-031 Under rst: pc_sel=10, pc_en=0, vec_rd=0, push_pc=0, flush=0, int_ack=0; vec_rd rises on the first clock after rst deasserts.
REQ-032 rst mid-push or mid-vector SHALL abandon the sequence with no further push_pc or int_ack.

Structure
REQ-033 Package pc_seq_pkg SHALL hold the state enum and the pc_sel encodings SEL_INT=00, SEL_FIRST=01, SEL_NEXT=10, SEL_BRANCH=11, shared with the PC mux.
REQ-034 Single module with registered state, counter, and int_active; no sub-module (next-state/output logic combinational).

Verification
REQ-035 Release rst, mem_ready high on the 3rd cycle -> vec_rd/vec_sel=0 for 3 cycles, then pc_sel=01 and pc_en=1 for one cycle, then pc_sel=10 and pc_en=1 every cycle.
REQ-036 In RUN, int_req=1 with PUSH_BEATS=2 and mem_ready 1 cycle later -> flush 1 cycle, push_pc 2 cycles, vec_rd/vec_sel=1 for 2 cycles, then pc_sel=00 with int_ack.
REQ-037 branch_taken=1, int_req=1, stall=1 together -> pc_sel=11, pc_en=1, flush=1; INT_PUSH entered the next cycle once stall drops.
REQ-038 Second int_req before rti -> ignored, pc_sel=10 stream; after rti pulse -> interrupt sequence starts the next cycle.
REQ-039 rst asserted during the 2nd push beat -> outputs drop immediately, int_active=0, RST_VEC sequence restarts.
